// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multiply/divide unit.
//   - op encodings driven on muldiv_unit.op
//   - FSM state enum
//   - twos_abs(): conditional two's-complement negation, used both to take
//     operand magnitudes and to restore result signs.
package muldiv_pkg;

   // Widest value the helper handles; covers the 2*WIDTH product for WIDTH <= 64.
   localparam int MAX_W = 128;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   // Magnitude of x given its sign flag (or, equivalently, apply a sign to a
   // magnitude). Callers zero-extend into MAX_W bits and truncate the result;
   // the low bits of a wide negation equal the narrow negation.
   function automatic logic [MAX_W-1:0] twos_abs(input logic [MAX_W-1:0] x,
                                                 input logic             neg);
      return neg ? (~x + MAX_W'(1)) : x;
   endfunction

endpackage

// File: rtl/div_restoring_step.sv
// div_restoring_step: one combinational iteration of restoring division.
// Ports:
//   rem_i     - partial remainder entering this step (always < divisor)
//   divisor_i - divisor magnitude
//   dvd_bit_i - next dividend bit shifted into the remainder
//   rem_o     - partial remainder after the trial subtraction
//   q_o       - quotient bit produced by this step
module div_restoring_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] divisor_i,
   input  logic             dvd_bit_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             q_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // The shifted remainder needs one extra bit; when the subtraction succeeds
   // the difference is below the divisor, so it fits back into WIDTH bits.
   assign shifted = {rem_i, dvd_bit_i};
   assign diff    = shifted - {1'b0, divisor_i};
   assign q_o     = (shifted >= {1'b0, divisor_i});
   assign rem_o   = q_o ? WIDTH'(diff) : WIDTH'(shifted);

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle signed/unsigned multiply and divide for the EX stage.
// Operands are converted to magnitudes on accept, processed unsigned, and the
// result sign is restored on the way into the hi/lo registers.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start, op, a, b - request (level), operation, rs/rt operands
//   flush           - cancel any in-flight operation
//   busy            - stall request (combinational)
//   done            - one-cycle pulse while the fresh hi/lo are presented
//   hi, lo          - product high/low half, or remainder/quotient
//   div_by_zero     - last divide had a zero divisor; valid with done, held
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter bit MUL_FAST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam int W2 = 2 * WIDTH;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             neg_res_q, neg_res_d;
   logic             neg_rem_q, neg_rem_d;
   logic             is_div_q, is_div_d;
   logic             bz_q, bz_d;
   logic             dz_q, dz_d;
   logic             done_q, done_d;

   logic             accept, finish;
   logic             is_div_op, signed_op, neg_a, neg_b;
   logic [WIDTH-1:0] a_abs, b_abs;
   logic [WIDTH:0]   mul_sum;
   logic [W2-1:0]    prod_fast, prod_res;
   logic [WIDTH-1:0] step_rem;
   logic             step_q;

   assign is_div_op = (op == OP_DIV) || (op == OP_DIVU);
   assign signed_op = (op == OP_MULT) || (op == OP_DIV);
   assign neg_a     = signed_op & a[WIDTH-1];
   assign neg_b     = signed_op & b[WIDTH-1];
   assign a_abs     = WIDTH'(twos_abs(MAX_W'(a), neg_a));
   assign b_abs     = WIDTH'(twos_abs(MAX_W'(b), neg_b));

   assign accept = (state_q == S_IDLE) && start && !flush;
   assign busy   = !rst && (accept || (state_q == S_MUL) || (state_q == S_DIV));

   // Divide: acc holds the partial remainder, quo shifts the dividend out of
   // its top while quotient bits enter at the bottom.
   div_restoring_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     (acc_q),
      .divisor_i (opnd_q),
      .dvd_bit_i (quo_q[WIDTH-1]),
      .rem_o     (step_rem),
      .q_o       (step_q)
   );

   // Iterative multiply: {acc, quo} shifts right, multiplier bits leave quo[0].
   assign mul_sum = {1'b0, acc_q} + (quo_q[0] ? {1'b0, opnd_q} : '0);

   generate
      if (MUL_FAST) begin : g_fast_mul
         assign prod_fast = W2'(opnd_q) * W2'(quo_q);
      end else begin : g_iter_mul
         assign prod_fast = '0;
      end
   endgenerate

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      opnd_d    = opnd_q;
      acc_d     = acc_q;
      quo_d     = quo_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      is_div_d  = is_div_q;
      bz_d      = bz_q;
      dz_d      = dz_q;
      done_d    = 1'b0;
      finish    = 1'b0;
      prod_res  = '0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               cnt_d     = '0;
               acc_d     = '0;
               neg_res_d = neg_a ^ neg_b;
               neg_rem_d = neg_a;
               is_div_d  = is_div_op;
               bz_d      = (b == '0);
               if (is_div_op) begin
                  state_d = S_DIV;
                  quo_d   = a_abs;
                  opnd_d  = b_abs;
               end else begin
                  state_d = S_MUL;
                  quo_d   = b_abs;
                  opnd_d  = a_abs;
               end
            end
         end
         S_MUL: begin
            if (flush) begin
               state_d = S_IDLE;
            end else if (MUL_FAST) begin
               {acc_d, quo_d} = prod_fast;
               finish         = 1'b1;
            end else begin
               {acc_d, quo_d} = {mul_sum, quo_q[WIDTH-1:1]};
               cnt_d          = cnt_q + 1'b1;
               finish         = (cnt_q == CW'(WIDTH - 1));
            end
         end
         S_DIV: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               acc_d  = step_rem;
               quo_d  = {quo_q[WIDTH-2:0], step_q};
               cnt_d  = cnt_q + 1'b1;
               finish = (cnt_q == CW'(WIDTH - 1));
            end
         end
         S_DONE: begin
            // start is deliberately ignored here so the stalled op is not re-issued
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Sign correction on the final working values; hi/lo are presented in DONE.
      if (finish) begin
         state_d  = S_DONE;
         done_d   = 1'b1;
         prod_res = W2'(twos_abs(MAX_W'({acc_d, quo_d}), neg_res_q));
         if (is_div_q) begin
            // A zero divisor naturally leaves |a| in the remainder, so the
            // remainder sign rule alone restores the raw dividend in hi.
            lo_d = bz_q ? '1 : WIDTH'(twos_abs(MAX_W'(quo_d), neg_res_q));
            hi_d = WIDTH'(twos_abs(MAX_W'(acc_d), neg_rem_q));
            dz_d = bz_q;
         end else begin
            {hi_d, lo_d} = prod_res;
            dz_d         = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      quo_q     <= quo_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      is_div_q  <= is_div_d;
      bz_q      <= bz_d;
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         dz_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dz_q    <= dz_d;
         done_q  <= done_d;
      end
   end

   assign done        = done_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign div_by_zero = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH = 32). Two instances share the inputs:
// u_fast uses the single-cycle multiplier, u_iter the shift-add multiplier.
module tb_muldiv_unit;

   localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

   logic        clk = 1'b0;
   logic        rst, start, flush;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        busy_f, done_f, dz_f, busy_i, done_i, dz_i;
   logic [31:0] hi_f, lo_f, hi_i, lo_i;
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(32), .MUL_FAST(1'b1)) u_fast (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
      .busy(busy_f), .done(done_f), .hi(hi_f), .lo(lo_f), .div_by_zero(dz_f));

   muldiv_unit #(.WIDTH(32), .MUL_FAST(1'b0)) u_iter (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
      .busy(busy_i), .done(done_i), .hi(hi_i), .lo(lo_i), .div_by_zero(dz_i));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op for a single cycle, then watch both instances for 40 cycles.
   task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                      input int lat_f, input int lat_i,
                      input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                      input string tag);
      int   df, di, nf, ni;
      logic dzf, dzi;
      df = -1; di = -1; nf = 0; ni = 0; dzf = 1'b0; dzi = 1'b0;
      op = o; a = x; b = y; start = 1'b1;
      #1;
      chk({tag, " busy_accept_f"}, busy_f, 1);
      chk({tag, " busy_accept_i"}, busy_i, 1);
      tick();
      start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (done_f) begin nf++; if (df < 0) begin df = c; dzf = dz_f; end end
         if (done_i) begin ni++; if (di < 0) begin di = c; dzi = dz_i; end end
         if (c == lat_f - 1) chk({tag, " busy_last_f"}, busy_f, 1);
         if (c == lat_f)     chk({tag, " busy_done_f"}, busy_f, 0);
         if (c == lat_i - 1) chk({tag, " busy_last_i"}, busy_i, 1);
         if (c == lat_i)     chk({tag, " busy_done_i"}, busy_i, 0);
         tick();
      end
      chk({tag, " lat_f"}, 64'(df), 64'(lat_f));
      chk({tag, " lat_i"}, 64'(di), 64'(lat_i));
      chk({tag, " ndone_f"}, 64'(nf), 1);
      chk({tag, " ndone_i"}, 64'(ni), 1);
      chk({tag, " dz_at_done_f"}, dzf, edz);
      chk({tag, " dz_at_done_i"}, dzi, edz);
      chk({tag, " hi_f"}, hi_f, ehi);
      chk({tag, " lo_f"}, lo_f, elo);
      chk({tag, " hi_i"}, hi_i, ehi);
      chk({tag, " lo_i"}, lo_i, elo);
      chk({tag, " dz_held_f"}, dz_f, edz);
      chk({tag, " dz_held_i"}, dz_i, edz);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          nd;
      logic [6:0]  dv;

      rst = 1'b1; start = 1'b0; flush = 1'b0; op = MULT; a = '0; b = '0;
      tick(); tick();
      chk("reset busy_f", busy_f, 0);
      chk("reset done_f", done_f, 0);
      chk("reset hi_f", hi_f, 0);
      chk("reset lo_f", lo_f, 0);
      chk("reset dz_f", dz_f, 0);
      chk("reset busy_i", busy_i, 0);
      chk("reset hi_i", hi_i, 0);
      chk("reset lo_i", lo_i, 0);
      rst = 1'b0;
      tick();

      run(DIVU,  32'd100,      32'd7,        33, 33, 32'd2,        32'd14,       1'b0, "divu_100_7");
      run(DIV,   32'hFFFFFFF9, 32'd2,        33, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_m7_2");
      run(DIV,   32'h80000000, 32'hFFFFFFFF, 33, 33, 32'h0,        32'h80000000, 1'b0, "div_ovf");
      run(MULT,  32'hFFFFFFFD, 32'd5,        2,  33, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, "mult_m3_5");
      run(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 2,  33, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max");
      run(DIV,   32'h1234,     32'd0,        33, 33, 32'h1234,     32'hFFFFFFFF, 1'b1, "div_by_0");

      // start held high: the fast unit must not re-accept in DONE, only in IDLE
      op = MULT; a = 32'hFFFFFFFE; b = 32'hFFFFFFFD; start = 1'b1;
      dv = '0; nd = 0;
      for (int c = 0; c <= 6; c++) begin
         if (c == 4) start = 1'b0;
         #1;
         dv[c] = done_f;
         if (done_i) nd++;
         if (c == 2) chk("hold busy_in_done_f", busy_f, 0);
         if (c == 3) chk("hold busy_reaccept_f", busy_f, 1);
         tick();
      end
      chk("hold done_pattern_f", dv, 7'b0100100);
      chk("hold hi_f", hi_f, 0);
      chk("hold lo_f", lo_f, 6);
      for (int c = 7; c <= 40; c++) begin
         if (done_i) nd++;
         tick();
      end
      chk("hold ndone_i", 64'(nd), 1);
      chk("hold hi_i", hi_i, 0);
      chk("hold lo_i", lo_i, 6);

      run(DIV, 32'd7, 32'hFFFFFFFE, 33, 33, 32'd1, 32'hFFFFFFFD, 1'b0, "div_7_m2");

      // flush at T+10 of a DIVU: no done, prior hi/lo kept
      op = DIVU; a = 32'd50; b = 32'd3; start = 1'b1;
      tick();
      start = 1'b0; nd = 0;
      for (int c = 1; c <= 9; c++) begin
         if (done_f || done_i) nd++;
         tick();
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      if (done_f || done_i) nd++;
      chk("flush busy_f", busy_f, 0);
      chk("flush busy_i", busy_i, 0);
      chk("flush no_done", 64'(nd), 0);
      chk("flush hi_kept", hi_f, 1);
      chk("flush lo_kept", lo_f, 32'hFFFFFFFD);
      tick();
      run(DIVU, 32'd9, 32'd2, 33, 33, 32'd1, 32'd4, 1'b0, "divu_after_flush");

      // flush in the accept cycle blocks acceptance
      op = DIVU; a = 32'd9; b = 32'd2; start = 1'b1; flush = 1'b1;
      #1;
      chk("flush_acc busy_f", busy_f, 0);
      tick();
      start = 1'b0; flush = 1'b0; nd = 0;
      chk("flush_acc busy_next_f", busy_f, 0);
      chk("flush_acc busy_next_i", busy_i, 0);
      for (int c = 0; c < 40; c++) begin
         if (done_f || done_i) nd++;
         tick();
      end
      chk("flush_acc no_done", 64'(nd), 0);

      // reset at T+5 of a DIVU
      op = DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 4; c++) tick();
      rst = 1'b1;
      #1;
      chk("rst_mid busy_comb_f", busy_f, 0);
      tick();
      rst = 1'b0;
      chk("rst_mid busy_f", busy_f, 0);
      chk("rst_mid hi_f", hi_f, 0);
      chk("rst_mid lo_f", lo_f, 0);
      chk("rst_mid hi_i", hi_i, 0);
      chk("rst_mid lo_i", lo_i, 0);
      nd = 0;
      for (int c = 0; c < 40; c++) begin
         if (done_f || done_i) nd++;
         tick();
      end
      chk("rst_mid no_done", 64'(nd), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
